// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 frame-buffer write side: arbiter state encoding,
// pixel layout and the pixel-address width derivation.
package hub75_pkg;

   typedef enum logic [1:0] {
      FB_IDLE      = 2'd0,
      FB_GRANT     = 2'd1,
      FB_SWAP_WAIT = 2'd2
   } fb_arb_state_t;

   localparam int PIX_BPP = 8;

   typedef struct packed {
      logic [PIX_BPP-1:0] r;
      logic [PIX_BPP-1:0] g;
      logic [PIX_BPP-1:0] b;
   } pixel_t;

   function automatic int addr_width(input int hpix, input int vpix);
      return $clog2(hpix * vpix);
   endfunction

endpackage

// File: rtl/hub75_rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after i_ptr,
// wrapping cyclically, so the last winner has lowest priority.
module hub75_rr_arbiter
   import hub75_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic          o_any,
   output logic [IW-1:0] o_idx
);

   logic [IW-1:0] w_idx;

   always_comb begin
      o_any = 1'b0;
      o_idx = '0;
      w_idx = '0;
      for (int k = 1; k <= N; k++) begin
         w_idx = IW'((int'(i_ptr) + k) % N);
         if (!o_any && i_req[w_idx]) begin
            o_any = 1'b1;
            o_idx = w_idx;
         end
      end
   end

endmodule

// File: rtl/hub75_fb_arbiter.sv
// Frame-buffer write-port arbiter with burst-locked round-robin grants and
// end-of-frame bank swap. Define HUB75_FB_ARB_TIMEOUT_EN to revoke idle grants.
module hub75_fb_arbiter
   import hub75_pkg::*;
#(
   parameter int  hpixel_p  = 64,
   parameter int  vpixel_p  = 64,
   parameter int  bpp_p     = 8,
   parameter int  num_req_p = 2,
   parameter int  timeout_p = 255,
   localparam int AW        = addr_width(hpixel_p, vpixel_p),
   localparam int DW        = 3 * bpp_p,
   localparam int IW        = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [num_req_p-1:0]    i_req_valid,
   input  logic [num_req_p-1:0]    i_req_last,
   input  logic [num_req_p*AW-1:0] i_req_addr,
   input  logic [num_req_p*DW-1:0] i_req_data,
   output logic [num_req_p-1:0]    o_req_ready,
   input  logic                    i_swap_req,
   input  logic                    i_frame_done,
   output logic                    o_fb_wr_en,
   output logic [AW:0]             o_fb_wr_addr,
   output logic [DW-1:0]           o_fb_wr_data,
   output logic                    o_rd_bank,
   output logic                    o_swap_done,
   output logic                    o_busy
);

   fb_arb_state_t r_state, w_state_nxt;
   logic [IW-1:0] r_grant, w_grant_nxt;
   logic [IW-1:0] r_ptr, w_ptr_nxt;
   logic          r_swap_pend, w_swap_pend_nxt;
   logic          r_rd_bank, w_rd_bank_nxt;
   logic          r_swap_done, w_swap_done_nxt;
   logic          r_wr_en;
   logic [AW:0]   r_wr_addr;
   logic [DW-1:0] r_wr_data;
   logic          w_any;
   logic [IW-1:0] w_pick;
   logic          w_accept;
   logic          w_last;
   logic          w_timeout;

   hub75_rr_arbiter #(
      .N  (num_req_p),
      .IW (IW)
   ) u_rr (
      .i_req (i_req_valid),
      .i_ptr (r_ptr),
      .o_any (w_any),
      .o_idx (w_pick)
   );

   assign w_accept = (r_state == FB_GRANT) && i_req_valid[r_grant];
   assign w_last   = w_accept && i_req_last[r_grant];

`ifdef HUB75_FB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(timeout_p + 1);
   logic [CW-1:0] r_idle_cnt;

   // Counts consecutive granted cycles without a beat from the owner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idle_cnt <= '0;
      end else if ((r_state != FB_GRANT) || w_accept) begin
         r_idle_cnt <= '0;
      end else begin
         r_idle_cnt <= r_idle_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state == FB_GRANT) && !i_req_valid[r_grant] &&
                      (r_idle_cnt == CW'(timeout_p - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_grant_nxt     = r_grant;
      w_ptr_nxt       = r_ptr;
      w_rd_bank_nxt   = r_rd_bank;
      w_swap_done_nxt = 1'b0;
      w_swap_pend_nxt = r_swap_pend | i_swap_req;
      o_req_ready     = '0;
      case (r_state)
         FB_IDLE: begin
            if (r_swap_pend) begin
               w_state_nxt = FB_SWAP_WAIT;
            end else if (w_any) begin
               w_state_nxt = FB_GRANT;
               w_grant_nxt = w_pick;
            end
         end
         FB_GRANT: begin
            o_req_ready[r_grant] = 1'b1;
            if (w_last || w_timeout) begin
               w_state_nxt = FB_IDLE;
               w_ptr_nxt   = r_grant;
            end
         end
         FB_SWAP_WAIT: begin
            // A swap request arriving here merges into the one being served.
            if (i_frame_done) begin
               w_state_nxt     = FB_IDLE;
               w_rd_bank_nxt   = ~r_rd_bank;
               w_swap_done_nxt = 1'b1;
               w_swap_pend_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = FB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= FB_IDLE;
         r_grant     <= '0;
         r_ptr       <= IW'(num_req_p - 1);
         r_swap_pend <= 1'b0;
         r_rd_bank   <= 1'b0;
         r_swap_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_ptr       <= w_ptr_nxt;
         r_swap_pend <= w_swap_pend_nxt;
         r_rd_bank   <= w_rd_bank_nxt;
         r_swap_done <= w_swap_done_nxt;
      end
   end

   // Writes always land in the back bank, i.e. the one not being displayed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_accept;
         if (w_accept) begin
            r_wr_addr <= {~r_rd_bank, i_req_addr[r_grant*AW +: AW]};
            r_wr_data <= i_req_data[r_grant*DW +: DW];
         end
      end
   end

   assign o_fb_wr_en   = r_wr_en;
   assign o_fb_wr_addr = r_wr_addr;
   assign o_fb_wr_data = r_wr_data;
   assign o_rd_bank    = r_rd_bank;
   assign o_swap_done  = r_swap_done;
   assign o_busy       = (r_state != FB_IDLE);

endmodule

// File: tb/tb_hub75_fb_arbiter.sv
// Self-checking bench for hub75_fb_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model with an expected-write queue.
`timescale 1ns/1ps
module tb_hub75_fb_arbiter;

   localparam int HP  = 64;
   localparam int VP  = 64;
   localparam int BPP = 8;
   localparam int NR  = 2;
   localparam int TO  = 8;
   localparam int AW  = $clog2(HP * VP);
   localparam int DW  = 3 * BPP;
   localparam int EW  = AW + 1 + DW;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_last = '0;
   logic [NR*AW-1:0]  req_addr = '0;
   logic [NR*DW-1:0]  req_data = '0;
   logic [NR-1:0]     req_ready;
   logic              swap_req = 1'b0;
   logic              frame_done = 1'b0;
   logic              fb_wr_en;
   logic [AW:0]       fb_wr_addr;
   logic [DW-1:0]     fb_wr_data;
   logic              rd_bank;
   logic              swap_done;
   logic              busy;

   hub75_fb_arbiter #(
      .hpixel_p  (HP),
      .vpixel_p  (VP),
      .bpp_p     (BPP),
      .num_req_p (NR),
      .timeout_p (TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_req_valid  (req_valid),
      .i_req_last   (req_last),
      .i_req_addr   (req_addr),
      .i_req_data   (req_data),
      .o_req_ready  (req_ready),
      .i_swap_req   (swap_req),
      .i_frame_done (frame_done),
      .o_fb_wr_en   (fb_wr_en),
      .o_fb_wr_addr (fb_wr_addr),
      .o_fb_wr_data (fb_wr_data),
      .o_rd_bank    (rd_bank),
      .o_swap_done  (swap_done),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int n_checks = 0;
   int n_fail   = 0;

   // producer driver state
   int            b_rem   [NR];
   logic [AW-1:0] b_addr  [NR];
   logic [DW-1:0] b_data  [NR];
   bit            b_rand  [NR];
   bit            b_gap   [NR];
   bit            b_stall [NR];
   int            gap_pct = 0;
   logic [NR-1:0] hs_obs;

   // reference model: m_owner = -1 idle, -2 waiting for frame end, else owner
   int   m_owner;
   int   m_ptr;
   int   m_cnt;
   bit   m_bank;
   bit   m_pend;
   bit   m_swap_done;
   logic [EW-1:0] exp_q[$];

   // observation logs
   int            cyc = 0;
   int            grant_log[$];
   int            wr_cyc_q[$];
   logic          last_wr_msb;
   int            n_done_pulses = 0;
   logic [NR-1:0] prev_ready;

   function automatic int rr_pick(logic [NR-1:0] v, int ptr);
      for (int k = 1; k <= NR; k++) begin
         if (v[(ptr + k) % NR]) return (ptr + k) % NR;
      end
      return -1;
   endfunction

   task automatic drive();
      for (int r = 0; r < NR; r++) begin
         req_valid[r]            = (b_rem[r] > 0) && !b_gap[r] && !b_stall[r];
         req_last[r]             = (b_rem[r] == 1);
         req_addr[r*AW +: AW]    = b_addr[r];
         req_data[r*DW +: DW]    = b_data[r];
      end
   endtask

   task automatic start_burst(input int r, input int len, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input bit rnd);
      b_rem[r]  = len;
      b_addr[r] = a;
      b_data[r] = d;
      b_rand[r] = rnd;
      drive();
   endtask

   task automatic model_reset();
      m_owner     = -1;
      m_ptr       = NR - 1;
      m_cnt       = 0;
      m_bank      = 1'b0;
      m_pend      = 1'b0;
      m_swap_done = 1'b0;
      exp_q.delete();
      prev_ready  = '0;
      for (int r = 0; r < NR; r++) begin
         b_rem[r]   = 0;
         b_gap[r]   = 1'b0;
         b_stall[r] = 1'b0;
      end
      swap_req   = 1'b0;
      frame_done = 1'b0;
      drive();
   endtask

   // Compare DUT outputs with the model, then advance the model by one edge.
   task automatic check_and_model();
      logic [NR-1:0] exp_ready;
      logic [EW-1:0] e;
      int            nxt;
      bit            cleared;
      exp_ready = '0;
      if (m_owner >= 0) exp_ready[m_owner] = 1'b1;
      n_checks++;
      if (req_ready !== exp_ready) begin
         n_fail++;
         $display("FAIL ready @%0t: got %b want %b", $time, req_ready, exp_ready);
      end
      n_checks++;
      if (busy !== (m_owner != -1)) begin
         n_fail++;
         $display("FAIL busy @%0t: got %b want %b", $time, busy, (m_owner != -1));
      end
      n_checks++;
      if (rd_bank !== m_bank) begin
         n_fail++;
         $display("FAIL rd_bank @%0t: got %b want %b", $time, rd_bank, m_bank);
      end
      n_checks++;
      if (swap_done !== m_swap_done) begin
         n_fail++;
         $display("FAIL swap_done @%0t: got %b want %b", $time, swap_done, m_swap_done);
      end
      n_checks++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (fb_wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_en @%0t: got %b want 1", $time, fb_wr_en);
         end
         n_checks++;
         if ({fb_wr_addr, fb_wr_data} !== e) begin
            n_fail++;
            $display("FAIL wr_beat @%0t: got %h/%h want %h/%h", $time,
                     fb_wr_addr, fb_wr_data, e[EW-1:DW], e[DW-1:0]);
         end
      end else if (fb_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_en @%0t: got %b want 0", $time, fb_wr_en);
      end

      if (fb_wr_en === 1'b1) begin
         wr_cyc_q.push_back(cyc);
         last_wr_msb = fb_wr_addr[AW];
      end
      for (int r = 0; r < NR; r++) begin
         if (req_ready[r] === 1'b1 && prev_ready[r] !== 1'b1) grant_log.push_back(r);
      end
      prev_ready = req_ready;
      if (swap_done === 1'b1) n_done_pulses++;
      hs_obs = req_valid & req_ready;
      cyc++;

      m_swap_done = 1'b0;
      cleared     = 1'b0;
      nxt         = m_owner;
      if (m_owner >= 0) begin
         if (req_valid[m_owner]) begin
            exp_q.push_back({~m_bank, req_addr[m_owner*AW +: AW], req_data[m_owner*DW +: DW]});
            m_cnt = 0;
            if (req_last[m_owner]) begin
               m_ptr = m_owner;
               nxt   = -1;
            end
         end else begin
`ifdef HUB75_FB_ARB_TIMEOUT_EN
            m_cnt++;
            if (m_cnt == TO) begin
               m_ptr = m_owner;
               nxt   = -1;
            end
`endif
         end
      end else if (m_owner == -1) begin
         if (m_pend) begin
            nxt = -2;
         end else if (req_valid != '0) begin
            nxt   = rr_pick(req_valid, m_ptr);
            m_cnt = 0;
         end
      end else if (frame_done) begin
         nxt         = -1;
         m_bank      = ~m_bank;
         m_swap_done = 1'b1;
         cleared     = 1'b1;
      end
      m_pend  = cleared ? 1'b0 : (m_pend | swap_req);
      m_owner = nxt;
   endtask

   task automatic cycle();
      @(negedge clk);
      check_and_model();
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
         if (hs_obs[r]) begin
            b_rem[r]--;
            b_addr[r] = b_addr[r] + 1'b1;
            b_data[r] = b_rand[r] ? DW'($urandom) : b_data[r] + 1'b1;
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) b_gap[r] = 1'b1;
         end else if (b_gap[r] && $urandom_range(0, 99) < 40) begin
            b_gap[r] = 1'b0;
         end
      end
      swap_req   = 1'b0;
      frame_done = 1'b0;
      drive();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      model_reset();
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({req_ready, fb_wr_en, fb_wr_addr, fb_wr_data, rd_bank, swap_done, busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_values: got ready=%b wr=%b a=%h d=%h bank=%b done=%b busy=%b want all 0",
                  req_ready, fb_wr_en, fb_wr_addr, fb_wr_data, rd_bank, swap_done, busy);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) cycle();
   endtask

   task automatic test_single_burst();
      int guard = 0;
      wr_cyc_q.delete();
      start_burst(0, 4, '0, 24'h112233, 1'b0);
      while ((b_rem[0] > 0 || exp_q.size() > 0) && guard < 50) begin
         cycle();
         guard++;
      end
      if (guard >= 50) begin
         n_checks++; n_fail++;
         $display("FAIL single_burst_bound: got %0d cycles want <50", guard);
      end
      repeat (2) cycle();
      n_checks++;
      if (wr_cyc_q.size() != 4) begin
         n_fail++;
         $display("FAIL single_burst_count: got %0d writes want 4", wr_cyc_q.size());
      end else begin
         n_checks++;
         if (wr_cyc_q[3] - wr_cyc_q[0] != 3) begin
            n_fail++;
            $display("FAIL single_burst_gapless: got span %0d want 3", wr_cyc_q[3] - wr_cyc_q[0]);
         end
      end
      n_checks++;
      if (last_wr_msb !== 1'b1) begin
         n_fail++;
         $display("FAIL single_burst_bank: got %b want 1", last_wr_msb);
      end
   endtask

   task automatic test_alternate();
      int left [NR];
      int guard = 0;
      apply_reset();
      grant_log.delete();
      for (int r = 0; r < NR; r++) begin
         start_burst(r, 2, AW'(r * 256), DW'($urandom), 1'b1);
         left[r] = 3;
      end
      while ((left[0] > 0 || left[1] > 0 || b_rem[0] > 0 || b_rem[1] > 0) && guard < 200) begin
         cycle();
         guard++;
         for (int r = 0; r < NR; r++) begin
            if (b_rem[r] == 0 && left[r] > 0) begin
               start_burst(r, 2, AW'($urandom), DW'($urandom), 1'b1);
               left[r]--;
            end
         end
      end
      if (guard >= 200) begin
         n_checks++; n_fail++;
         $display("FAIL alternate_bound: got %0d cycles want <200", guard);
      end
      repeat (2) cycle();
      n_checks++;
      if (grant_log.size() != 8) begin
         n_fail++;
         $display("FAIL alternate_count: got %0d grants want 8", grant_log.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (grant_log[k] != k % 2) begin
               n_fail++;
               $display("FAIL alternate_order[%0d]: got %0d want %0d", k, grant_log[k], k % 2);
            end
         end
      end
   endtask

   task automatic test_swap_mid_burst();
      int guard = 0;
      int pulses0;
      apply_reset();
      start_burst(1, 6, AW'(100), DW'($urandom), 1'b1);
      while (b_rem[1] > 4 && guard < 20) begin
         cycle();
         guard++;
      end
      swap_req = 1'b1;
      while (b_rem[1] > 0 && guard < 40) begin
         cycle();
         guard++;
      end
      if (guard >= 40) begin
         n_checks++; n_fail++;
         $display("FAIL swap_burst_bound: got %0d cycles want <40", guard);
      end
      pulses0 = n_done_pulses;
      repeat (5) cycle();
      frame_done = 1'b1;
      repeat (3) cycle();
      n_checks++;
      if (rd_bank !== 1'b1) begin
         n_fail++;
         $display("FAIL swap_bank: got %b want 1", rd_bank);
      end
      n_checks++;
      if (n_done_pulses - pulses0 != 1) begin
         n_fail++;
         $display("FAIL swap_done_pulses: got %0d want 1", n_done_pulses - pulses0);
      end
      start_burst(0, 2, AW'(7), DW'($urandom), 1'b1);
      repeat (6) cycle();
      n_checks++;
      if (last_wr_msb !== 1'b0) begin
         n_fail++;
         $display("FAIL swap_back_bank: got %b want 0", last_wr_msb);
      end
   endtask

   task automatic test_swap_merge();
      int pulses0;
      frame_done = 1'b1;
      repeat (3) cycle();
      n_checks++;
      if (rd_bank !== 1'b1) begin
         n_fail++;
         $display("FAIL stray_frame_done: got bank %b want 1", rd_bank);
      end
      pulses0 = n_done_pulses;
      swap_req = 1'b1;
      cycle();
      swap_req   = 1'b1;
      frame_done = 1'b1;
      cycle();
      repeat (2) cycle();
      frame_done = 1'b1;
      repeat (4) cycle();
      frame_done = 1'b1;
      repeat (3) cycle();
      n_checks++;
      if (n_done_pulses - pulses0 != 1) begin
         n_fail++;
         $display("FAIL merge_pulses: got %0d want 1", n_done_pulses - pulses0);
      end
      n_checks++;
      if (rd_bank !== 1'b0) begin
         n_fail++;
         $display("FAIL merge_bank: got %b want 0", rd_bank);
      end
   endtask

   task automatic test_reset_mid_burst();
      int guard = 0;
      swap_req = 1'b1;
      repeat (3) cycle();
      frame_done = 1'b1;
      repeat (2) cycle();
      start_burst(0, 8, AW'(40), DW'($urandom), 1'b1);
      repeat (4) cycle();
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({req_ready, fb_wr_en, fb_wr_addr, fb_wr_data, rd_bank, swap_done, busy} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got ready=%b wr=%b a=%h d=%h bank=%b done=%b busy=%b want all 0",
                  req_ready, fb_wr_en, fb_wr_addr, fb_wr_data, rd_bank, swap_done, busy);
      end
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      grant_log.delete();
      start_burst(1, 2, AW'(9), DW'($urandom), 1'b1);
      start_burst(0, 2, AW'(3), DW'($urandom), 1'b1);
      while (grant_log.size() == 0 && guard < 10) begin
         cycle();
         guard++;
      end
      n_checks++;
      if (grant_log.size() == 0 || grant_log[0] != 0) begin
         n_fail++;
         $display("FAIL reset_first_grant: got %0d want 0",
                  (grant_log.size() == 0) ? -1 : grant_log[0]);
      end
      repeat (10) cycle();
   endtask

`ifdef HUB75_FB_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int guard = 0;
      apply_reset();
      grant_log.delete();
      start_burst(0, 4, AW'(0), DW'($urandom), 1'b1);
      cycle();
      start_burst(1, 2, AW'(50), DW'($urandom), 1'b1);
      while (b_rem[0] > 3 && guard < 10) begin
         cycle();
         guard++;
      end
      b_stall[0] = 1'b1;
      drive();
      while (b_rem[1] > 0 && guard < 40) begin
         cycle();
         guard++;
      end
      b_stall[0] = 1'b0;
      drive();
      while (b_rem[0] > 0 && guard < 60) begin
         cycle();
         guard++;
      end
      if (guard >= 60) begin
         n_checks++; n_fail++;
         $display("FAIL timeout_bound: got %0d cycles want <60", guard);
      end
      repeat (2) cycle();
      n_checks++;
      if (grant_log.size() != 3 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0) begin
         n_fail++;
         $display("FAIL timeout_order: got %p want '{0,1,0}", grant_log);
      end
   endtask
`endif

   task automatic test_random();
      gap_pct = 30;
      for (int i = 0; i < 1500; i++) begin
         cycle();
         for (int r = 0; r < NR; r++) begin
            if (b_rem[r] == 0 && $urandom_range(0, 99) < 50)
               start_burst(r, $urandom_range(1, 6), AW'($urandom), DW'($urandom), 1'b1);
         end
         swap_req   = ($urandom_range(0, 99) < 3);
         frame_done = ($urandom_range(0, 99) < 6);
      end
      gap_pct = 0;
   endtask

   task automatic drain();
      int guard = 0;
      while ((b_rem[0] > 0 || b_rem[1] > 0 || exp_q.size() > 0) && guard < 300) begin
         frame_done = 1'b1;
         cycle();
         guard++;
      end
      if (guard >= 300) begin
         n_checks++; n_fail++;
         $display("FAIL drain_bound: got %0d cycles want <300", guard);
      end
      repeat (3) cycle();
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_alternate();
      test_swap_mid_burst();
      test_swap_merge();
      test_reset_mid_burst();
`ifdef HUB75_FB_ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
